// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: FSM state encodings and the state width
// used by fetch_ctrl and anything that decodes its state_o output.
package cpu_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALTED = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch/execute sequencer: requests instructions, waits for the
// datapath, latches the PC update controls and counts retired instructions.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int N           = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 halt,
  input  logic                 imem_ack,
  input  logic                 exec_done,
  input  logic                 jump,
  input  logic                 branch_taken,
  input  logic [N-1:0]         jump_address,
  input  logic [N-1:0]         branch_offset,
  output logic                 imem_req,
  output logic                 pc_en,
  output logic                 pc_jump,
  output logic                 pc_src,
  output logic [N-1:0]         pc_jump_address,
  output logic [N-1:0]         pc_branch_offset,
  output logic [31:0]          retired,
  output logic [STATE_W-1:0]   state_o,
  output logic                 err
);

  // The counter value at which one more missing ack trips the timeout.
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_t     state, next_state;
  logic [7:0] tmo_cnt, tmo_cnt_next;
  logic       halt_pending, halt_pending_next;

  assign state_o = state;

  always_comb begin
    next_state        = state;
    tmo_cnt_next      = tmo_cnt;
    halt_pending_next = halt_pending;

    case (state)
      ST_IDLE:   if (start) next_state = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack)                next_state = ST_EXEC;
        else if (tmo_cnt >= TMO_LAST) next_state = ST_ERROR;
        else                          tmo_cnt_next = tmo_cnt + 8'd1;
      end
      ST_EXEC:   if (exec_done) next_state = ST_UPDATE;
      ST_UPDATE: next_state = (halt || halt_pending) ? ST_HALTED : ST_FETCH;
      ST_HALTED: next_state = ST_HALTED;
      ST_ERROR:  next_state = ST_ERROR;
      default:   next_state = ST_IDLE;
    endcase

    // A halt request is remembered from one FETCH entry until it takes effect.
    if (next_state == ST_FETCH && state != ST_FETCH) begin
      tmo_cnt_next      = '0;
      halt_pending_next = 1'b0;
    end else if (next_state == ST_HALTED) begin
      halt_pending_next = 1'b0;
    end else if (halt && (state == ST_FETCH || state == ST_EXEC || state == ST_UPDATE)) begin
      halt_pending_next = 1'b1;
    end
  end

  // Outputs are decoded from next_state so they are registered yet line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      tmo_cnt          <= '0;
      halt_pending     <= 1'b0;
      imem_req         <= 1'b0;
      pc_en            <= 1'b0;
      pc_jump          <= 1'b0;
      pc_src           <= 1'b0;
      pc_jump_address  <= '0;
      pc_branch_offset <= '0;
      retired          <= '0;
      err              <= 1'b0;
    end else begin
      state        <= next_state;
      tmo_cnt      <= tmo_cnt_next;
      halt_pending <= halt_pending_next;
      imem_req     <= (next_state == ST_FETCH);
      pc_en        <= (next_state == ST_UPDATE);
      err          <= err | (next_state == ST_ERROR);
      if (state == ST_EXEC && exec_done) begin
        pc_jump          <= jump;
        pc_src           <= branch_taken & ~jump;
        pc_jump_address  <= jump_address;
        pc_branch_offset <= branch_offset;
        retired          <= retired + 32'd1;
      end
    end
  end

endmodule
